// File: rtl/cpu_mc.sv
// cpu_mc: parameterised multicycle register CPU (unpipelined) with a
// req/ack memory port that tolerates wait states. Stages:
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH, plus a terminal HALT.
module cpu_mc #(
  parameter int          BITS_DATA = 32,
  parameter int          BITS_ADDR = 16,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [BITS_ADDR-1:0] mem_addr,
  output logic [BITS_DATA-1:0] mem_wdata,
  input  logic [BITS_DATA-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic                 halted,
  output logic                 err,
  output logic [BITS_ADDR-1:0] dbg_pc
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} stage_e;

  localparam logic [4:0] OP_NOP = 5'd0,  OP_ADD = 5'd1, OP_SUB = 5'd2, OP_AND = 5'd3;
  localparam logic [4:0] OP_OR  = 5'd4,  OP_XOR = 5'd5, OP_ADDI = 5'd6, OP_LD = 5'd7;
  localparam logic [4:0] OP_ST  = 5'd8,  OP_BEQ = 5'd9, OP_JMP = 5'd10, OP_HLT = 5'd31;
  localparam logic [BITS_ADDR-1:0] PC_RST = BITS_ADDR'(RESET_PC);
  localparam logic [BITS_ADDR-1:0] PC_ONE = BITS_ADDR'(1);

  stage_e               stage_q, stage_d;
  logic [BITS_ADDR-1:0] pc_q, pc_d, addr_q, addr_d;
  logic [31:0]          ir_q, ir_d;
  logic [BITS_DATA-1:0] a_q, a_d, b_q, b_d, c_q, c_d, res_q, res_d, wdata_q, wdata_d;
  logic [BITS_DATA-1:0] regs_q [8];
  logic                 req_q, req_d, we_q, we_d, err_q, err_d, rf_we;

  // Instruction fields; bits [17:16] carry nothing.
  logic [4:0]           opc;
  logic [2:0]           rd, rs1, rs2;
  logic [BITS_DATA-1:0] imm_x;
  logic [BITS_ADDR-1:0] ea;
  logic                 hs;
  logic                 unused_ir;

  assign opc       = ir_q[31:27];
  assign rd        = ir_q[26:24];
  assign rs1       = ir_q[23:21];
  assign rs2       = ir_q[20:18];
  assign imm_x     = {{(BITS_DATA-16){ir_q[15]}}, ir_q[15:0]};
  assign ea        = a_q[BITS_ADDR-1:0] + imm_x[BITS_ADDR-1:0];
  assign hs        = req_q & mem_ack;
  assign unused_ir = ^ir_q[17:16];

  // State and datapath registers; reset wins over any pending handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= S_FETCH;
      pc_q    <= PC_RST;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      stage_q <= stage_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      res_q   <= res_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      if (rf_we && rd != 3'd0) regs_q[rd] <= res_q;
    end
  end

  // Next stage.
  always_comb begin
    stage_d = stage_q;
    case (stage_q)
      S_FETCH:  if (hs) stage_d = S_DECODE;
      S_DECODE: stage_d = S_EXEC;
      S_EXEC: begin
        case (opc)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: stage_d = S_WB;
          OP_LD, OP_ST:                                   stage_d = S_MEM;
          OP_NOP, OP_BEQ, OP_JMP:                         stage_d = S_FETCH;
          default:                                        stage_d = S_HALT;
        endcase
      end
      S_MEM:   if (hs) stage_d = (opc == OP_LD) ? S_WB : S_FETCH;
      S_WB:    stage_d = S_FETCH;
      default: stage_d = S_HALT;
    endcase
  end

  // Datapath and registered memory-port outputs. The request for the next
  // access is raised on the same edge that enters its stage, so the request
  // is already high during the owning stage's first cycle.
  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    res_d   = res_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rf_we   = 1'b0;
    case (stage_q)
      S_FETCH: begin
        if (hs) begin
          ir_d  = mem_rdata[31:0];
          pc_d  = pc_q + PC_ONE;
          req_d = 1'b0;
        end else if (!req_q) begin
          // only after reset: start the first fetch
          req_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = pc_q;
        end
      end
      S_DECODE: begin
        a_d = regs_q[rs1];
        b_d = regs_q[rs2];
        c_d = regs_q[rd];
      end
      S_EXEC: begin
        case (opc)
          OP_ADD:  res_d = a_q + b_q;
          OP_SUB:  res_d = a_q - b_q;
          OP_AND:  res_d = a_q & b_q;
          OP_OR:   res_d = a_q | b_q;
          OP_XOR:  res_d = a_q ^ b_q;
          OP_ADDI: res_d = a_q + imm_x;
          OP_LD, OP_ST: begin
            req_d   = 1'b1;
            we_d    = (opc == OP_ST);
            addr_d  = ea;
            wdata_d = c_q;
          end
          OP_NOP, OP_BEQ, OP_JMP: begin
            // PC was bumped at fetch, so a taken BEQ is relative to PC+1
            if (opc == OP_BEQ && c_q == a_q) pc_d = pc_q + imm_x[BITS_ADDR-1:0];
            if (opc == OP_JMP)               pc_d = ir_q[BITS_ADDR-1:0];
            req_d  = 1'b1;
            we_d   = 1'b0;
            addr_d = pc_d;
          end
          default: err_d = (opc != OP_HLT);
        endcase
      end
      S_MEM: begin
        if (hs) begin
          if (opc == OP_LD) begin
            res_d = mem_rdata;
            req_d = 1'b0;
          end else begin
            req_d  = 1'b1;
            addr_d = pc_q;
          end
          we_d = 1'b0;
        end
      end
      S_WB: begin
        rf_we  = 1'b1;
        req_d  = 1'b1;
        we_d   = 1'b0;
        addr_d = pc_q;
      end
      default: begin
        req_d = 1'b0;
        we_d  = 1'b0;
      end
    endcase
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign halted    = (stage_q == S_HALT);
  assign err       = err_q;
  assign dbg_pc    = pc_q;
endmodule

// File: tb/tb_cpu_mc.sv
// tb_cpu_mc: directed program tests for cpu_mc against a word memory model
// with a programmable number of wait states per access.
module tb_cpu_mc;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ack, halted, err;
  logic [15:0] mem_addr, dbg_pc;
  logic [31:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  cpu_mc #(.BITS_DATA(32), .BITS_ADDR(16), .RESET_PC(16)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .halted(halted), .err(err), .dbg_pc(dbg_pc)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Memory model: reads are combinational; ack rises after wait_n stalled cycles.
  logic [31:0] mem [0:65535];
  int          wait_n = 0;
  logic        ack_en = 1'b1;
  int          wcnt = 0;
  int          wr_cnt = 0;
  logic [15:0] wa [0:63];
  logic [31:0] wd [0:63];

  assign mem_ack   = ack_en && (wcnt == wait_n);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (reset || !mem_req || mem_ack) wcnt <= 0;
    else                              wcnt <= wcnt + 1;
    if (!reset && mem_req && mem_ack && mem_we) begin
      wa[wr_cnt % 64] <= mem_addr;
      wd[wr_cnt % 64] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // While a request is stalled its signals must not move.
  logic        chk_stable = 1'b0;
  logic        p_wait = 1'b0;
  logic        p_we = 1'b0;
  logic [15:0] p_addr = '0;
  logic [31:0] p_wd = '0;
  always @(negedge clk) begin
    if (chk_stable && p_wait) begin
      chk("stable_req", {31'd0, mem_req}, 32'd1);
      chk("stable_we", {31'd0, mem_we}, {31'd0, p_we});
      chk("stable_addr", {16'd0, mem_addr}, {16'd0, p_addr});
      if (p_we) chk("stable_wdata", mem_wdata, p_wd);
    end
    p_wait <= mem_req && !mem_ack;
    p_we   <= mem_we;
    p_addr <= mem_addr;
    p_wd   <= mem_wdata;
  end

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, 3'd0, 2'b00, imm};
  endfunction

  // Holds reset for two edges, leaving it asserted.
  task automatic hold_reset();
    reset = 1'b1;
    ack_en = 1'b1;
    wait_n = 0;
    repeat (2) @(negedge clk);
  endtask

  // Cycle index, counted from the first cycle with mem_req high, at which
  // halted is first seen; -1 if no request appears.
  task automatic run_halt(output int cyc);
    int n;
    n = 0;
    cyc = -1;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!mem_req) return;
    cyc = 0;
    while (!halted && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic next_fetch(output logic [15:0] a);
    a = 'x;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (mem_req && mem_ack && !mem_we) begin
        a = mem_addr;
        return;
      end
    end
  endtask

  task automatic load_alu_prog();
    mem[16'h10] = enc(5'd6, 3'd1, 3'd0, 16'd5);        // ADDI r1,r0,5
    mem[16'h11] = enc(5'd6, 3'd2, 3'd0, 16'hFFFD);     // ADDI r2,r0,-3
    mem[16'h12] = {5'd1, 3'd3, 3'd1, 3'd2, 18'd0};     // ADD r3,r1,r2
    mem[16'h13] = enc(5'd8, 3'd3, 3'd0, 16'h0100);     // ST r3,[r0+0x100]
    mem[16'h14] = enc(5'd31, 3'd0, 3'd0, 16'd0);       // HLT
  endtask

  initial begin
    int          cyc, base, nreq;
    logic [15:0] fa;
    logic        found;
    for (int i = 0; i < 65536; i++) mem[i] = '0;

    // Reset state and first fetch
    load_alu_prog();
    hold_reset();
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_pc", {16'd0, dbg_pc}, 32'h10);
    reset = 1'b0;
    @(negedge clk);
    chk("fetch_req", {31'd0, mem_req}, 32'd1);
    chk("fetch_addr", {16'd0, mem_addr}, 32'h10);
    chk("fetch_we", {31'd0, mem_we}, 32'd0);

    // ALU + store + halt, zero wait: 4+4+4+4+3 cycles
    base = wr_cnt;
    run_halt(cyc);
    chk("alu_cycles", cyc, 32'd19);
    chk("alu_halted", {31'd0, halted}, 32'd1);
    chk("alu_err", {31'd0, err}, 32'd0);
    chk("alu_nwr", wr_cnt - base, 32'd1);
    chk("alu_waddr", {16'd0, wa[base % 64]}, 32'h100);
    chk("alu_wdata", wd[base % 64], 32'h2);

    // Same program, 2 wait states per access: six accesses (five fetches
    // plus the store) add 12 cycles
    hold_reset();
    wait_n = 2;
    chk_stable = 1'b1;
    reset = 1'b0;
    base = wr_cnt;
    run_halt(cyc);
    chk_stable = 1'b0;
    chk("ws_cycles", cyc, 32'd31);
    chk("ws_nwr", wr_cnt - base, 32'd1);
    chk("ws_waddr", {16'd0, wa[base % 64]}, 32'h100);
    chk("ws_wdata", wd[base % 64], 32'h2);

    // Taken branch loops on itself: BEQ r0,r0,-1 at 0x0005
    mem[16'h10] = enc(5'd10, 3'd0, 3'd0, 16'h0005);
    mem[16'h05] = enc(5'd9, 3'd0, 3'd0, 16'hFFFF);
    hold_reset();
    reset = 1'b0;
    next_fetch(fa); chk("br_f0", {16'd0, fa}, 32'h10);
    next_fetch(fa); chk("br_f1", {16'd0, fa}, 32'h05);
    next_fetch(fa); chk("br_f2", {16'd0, fa}, 32'h05);
    next_fetch(fa); chk("br_f3", {16'd0, fa}, 32'h05);

    // PC wrap: JMP 0xFFFF (NOP there) -> fetch 0x0000 (HLT)
    mem[16'h10]   = enc(5'd10, 3'd0, 3'd0, 16'hFFFF);
    mem[16'hFFFF] = 32'd0;
    mem[16'h0000] = enc(5'd31, 3'd0, 3'd0, 16'd0);
    hold_reset();
    reset = 1'b0;
    next_fetch(fa); chk("wrap_f0", {16'd0, fa}, 32'h10);
    next_fetch(fa); chk("wrap_f1", {16'd0, fa}, 32'hFFFF);
    next_fetch(fa); chk("wrap_f2", {16'd0, fa}, 32'h0000);
    repeat (4) @(negedge clk);
    chk("wrap_halted", {31'd0, halted}, 32'd1);
    chk("wrap_err", {31'd0, err}, 32'd0);

    // Loads, and r0 as a load target / store source: 5+5+4+4+3 cycles
    mem[16'h20] = 32'hDEADBEEF;
    mem[16'h10] = enc(5'd7, 3'd4, 3'd0, 16'h0020);     // LD r4,[r0+0x20]
    mem[16'h11] = enc(5'd7, 3'd0, 3'd0, 16'h0020);     // LD r0,[r0+0x20]
    mem[16'h12] = enc(5'd8, 3'd4, 3'd0, 16'h0021);     // ST r4,[r0+0x21]
    mem[16'h13] = enc(5'd8, 3'd0, 3'd0, 16'h0022);     // ST r0,[r0+0x22]
    mem[16'h14] = enc(5'd31, 3'd0, 3'd0, 16'd0);       // HLT
    hold_reset();
    reset = 1'b0;
    base = wr_cnt;
    run_halt(cyc);
    chk("ld_cycles", cyc, 32'd21);
    chk("ld_nwr", wr_cnt - base, 32'd2);
    chk("ld_wa0", {16'd0, wa[base % 64]}, 32'h21);
    chk("ld_wd0", wd[base % 64], 32'hDEADBEEF);
    chk("ld_wa1", {16'd0, wa[(base + 1) % 64]}, 32'h22);
    chk("ld_wd1", wd[(base + 1) % 64], 32'h0);

    // Illegal opcode 0x15 traps and stops requesting
    mem[16'h10] = enc(5'h15, 3'd0, 3'd0, 16'd0);
    hold_reset();
    reset = 1'b0;
    run_halt(cyc);
    chk("ill_cycles", cyc, 32'd3);
    chk("ill_halted", {31'd0, halted}, 32'd1);
    chk("ill_err", {31'd0, err}, 32'd1);
    nreq = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_req) nreq++;
    end
    chk("ill_noreq", nreq, 32'd0);

    // Reset while a load waits for ack: r5/r6 get 7/9 on the first pass,
    // so the stores of the second pass show whether the file was cleared
    mem[16'h10] = enc(5'd8, 3'd5, 3'd0, 16'h0030);     // ST r5,[0x30]
    mem[16'h11] = enc(5'd8, 3'd6, 3'd0, 16'h0031);     // ST r6,[0x31]
    mem[16'h12] = enc(5'd6, 3'd5, 3'd0, 16'd7);        // ADDI r5,r0,7
    mem[16'h13] = enc(5'd6, 3'd6, 3'd0, 16'd9);        // ADDI r6,r0,9
    mem[16'h14] = enc(5'd7, 3'd6, 3'd0, 16'h0020);     // LD r6,[0x20]
    mem[16'h15] = enc(5'd31, 3'd0, 3'd0, 16'd0);       // HLT
    hold_reset();
    reset = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (mem_req && !mem_we && mem_addr == 16'h0020) begin
        ack_en = 1'b0;
        found = 1'b1;
      end
    end
    chk("mid_found", {31'd0, found}, 32'd1);
    repeat (2) @(negedge clk);
    chk("mid_wait_req", {31'd0, mem_req}, 32'd1);
    chk("mid_wait_addr", {16'd0, mem_addr}, 32'h20);
    reset = 1'b1;
    ack_en = 1'b1;                                     // ack coincides with reset edge
    @(negedge clk);
    chk("mid_req", {31'd0, mem_req}, 32'd0);
    chk("mid_err", {31'd0, err}, 32'd0);
    chk("mid_pc", {16'd0, dbg_pc}, 32'h10);
    reset = 1'b0;
    base = wr_cnt;
    next_fetch(fa);
    chk("mid_refetch", {16'd0, fa}, 32'h10);
    for (int n = 0; n < 100 && (wr_cnt - base) < 2; n++) @(negedge clk);
    chk("mid_nwr", wr_cnt - base, 32'd2);
    chk("mid_wa0", {16'd0, wa[base % 64]}, 32'h30);
    chk("mid_wd0", wd[base % 64], 32'h0);
    chk("mid_wa1", {16'd0, wa[(base + 1) % 64]}, 32'h31);
    chk("mid_wd1", wd[(base + 1) % 64], 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
